next_pc_gen: RTL and testbench



---
 rtl/next_pc_gen_if.sv | 25 ++
 rtl/next_pc_gen.sv | 52 +++++
 tb/tb_next_pc_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/next_pc_gen_if.sv
// next_pc_gen_if: fetch request, BTB lookup and branch-resolution signals of the next-PC generator
interface next_pc_gen_if;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] btb_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_mispredict;
  logic [31:0] btb_upd_addr;
  logic [31:0] btb_upd_entry;
  logic [31:0] mispredict_cnt;
  modport master (
    output fetch_pc, fetch_valid, pred_taken, pred_target, btb_upd_addr, btb_upd_entry, mispredict_cnt,
    input  fetch_ready, btb_target, resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_mispredict
  );
  modport slave (
    input  fetch_pc, fetch_valid, pred_taken, pred_target, btb_upd_addr, btb_upd_entry, mispredict_cnt,
    output fetch_ready, btb_target, resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_mispredict
  );
endinterface

// File: rtl/next_pc_gen.sv
// next_pc_gen: fetch PC register with BTB + 2-bit BHT prediction and mispredict redirect
module next_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [1:0]  BHT_INIT = 2'b01
) (
  input logic clk,
  input logic rst_n,
  next_pc_gen_if.master bus
);
  typedef enum logic [1:0] {INIT, RUN, REDIR} state_t;
  state_t state;
  logic [15:0][1:0] bht;
  logic [1:0] fetch_ctr, res_ctr, res_ctr_nxt;
  logic mis;
  assign fetch_ctr = bht[bus.fetch_pc[3:0]];
  assign res_ctr   = bht[bus.resolve_pc[3:0]];
  assign mis       = bus.resolve_valid && bus.resolve_mispredict;
  always_comb begin
    bus.pred_taken  = bus.fetch_valid && fetch_ctr[1] && (bus.btb_target != '0);
    bus.pred_target = bus.pred_taken ? bus.btb_target : bus.fetch_pc + 32'd4;
    res_ctr_nxt     = bus.resolve_taken ? ((res_ctr == 2'b11) ? res_ctr : res_ctr + 2'd1)
                                        : ((res_ctr == 2'b00) ? res_ctr : res_ctr - 2'd1);
  end
  // fetch_valid is kept equal to (state == RUN) but registered so it never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= INIT;
      bus.fetch_valid    <= 1'b0;
      bus.fetch_pc       <= RESET_PC;
      bht                <= {16{BHT_INIT}};
      bus.btb_upd_addr   <= '0;
      bus.btb_upd_entry  <= '0;
      bus.mispredict_cnt <= '0;
    end else begin
      if (mis) begin
        state              <= REDIR;
        bus.fetch_valid    <= 1'b0;
        bus.fetch_pc       <= bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
        bus.mispredict_cnt <= bus.mispredict_cnt + 32'd1;
      end else begin
        state           <= RUN;
        bus.fetch_valid <= 1'b1;
        if (state == RUN && bus.fetch_ready) bus.fetch_pc <= bus.pred_target;
      end
      if (bus.resolve_valid) bht[bus.resolve_pc[3:0]] <= res_ctr_nxt;
      if (bus.resolve_valid && bus.resolve_taken) begin
        bus.btb_upd_addr  <= bus.resolve_pc;
        bus.btb_upd_entry <= bus.resolve_target;
      end
    end
  end
endmodule

// File: tb/tb_next_pc_gen.sv
// tb_next_pc_gen: directed + random stimulus, per-cycle expectations queued by a spec-level model
module tb_next_pc_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  next_pc_gen_if bus();
  next_pc_gen #(.RESET_PC(32'h100), .BHT_INIT(2'b01)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg, cnt, ua, ue;
  } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  bit mon_en = 1'b0;
  logic [31:0] m_pc, m_cnt, m_ua, m_ue;
  bit m_started, m_blank;
  int m_bht[16];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  // Drives one cycle of inputs, queues what the DUT should show during it, advances the model.
  task automatic cycle(input logic rdy, input logic [31:0] bt, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtg, input logic rm);
    exp_t e;
    int i;
    bus.fetch_ready = rdy; bus.btb_target = bt;
    bus.resolve_valid = rv; bus.resolve_pc = rpc; bus.resolve_taken = rt;
    bus.resolve_target = rtg; bus.resolve_mispredict = rm;
    e.v   = m_started && !m_blank;
    e.pc  = m_pc;
    e.pt  = e.v && m_bht[m_pc % 16] >= 2 && bt != 0;
    e.ptg = e.pt ? bt : m_pc + 32'd4;
    e.cnt = m_cnt; e.ua = m_ua; e.ue = m_ue;
    q.push_back(e);
    if (rv) begin
      i = int'(rpc % 16);
      m_bht[i] = rt ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
      if (rt) begin m_ua = rpc; m_ue = rtg; end
    end
    if (rv && rm) begin
      m_pc = rt ? rtg : rpc + 32'd4;
      m_blank = 1'b1;
      m_cnt++;
    end else begin
      if (e.v && rdy) m_pc = e.ptg;
      m_blank = 1'b0;
    end
    m_started = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] bt);
    cycle(1'b1, bt, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_empty: got no expectation expected one at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.v));
          chk("fetch_pc", bus.fetch_pc, e.pc);
          chk("pred_taken", 32'(bus.pred_taken), 32'(e.pt));
          chk("pred_target", bus.pred_target, e.ptg);
          chk("mispredict_cnt", bus.mispredict_cnt, e.cnt);
          chk("btb_upd_addr", bus.btb_upd_addr, e.ua);
          chk("btb_upd_entry", bus.btb_upd_entry, e.ue);
        end
      end
    end
  end

  initial begin
    logic [31:0] bt;
    rst_n = 1'b0;
    bus.fetch_ready = 1'b1; bus.btb_target = '0; bus.resolve_valid = 1'b0; bus.resolve_pc = '0;
    bus.resolve_taken = 1'b0; bus.resolve_target = '0; bus.resolve_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_pc", bus.fetch_pc, 32'h100);
    chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    chk("rst_pred_target", bus.pred_target, 32'h104);
    chk("rst_cnt", bus.mispredict_cnt, 32'd0);
    chk("rst_upd_addr", bus.btb_upd_addr, 32'd0);
    chk("rst_upd_entry", bus.btb_upd_entry, 32'd0);
    m_pc = 32'h100; m_cnt = '0; m_ua = '0; m_ue = '0; m_started = 1'b0; m_blank = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    // sequential fetch, then a 3-cycle stall at 0x108
    repeat (3) idle(32'h0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0);
    idle(32'h0);
    // redirect to 0x104, which now predicts taken to 0x200
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    idle(32'h0);
    idle(32'h200);
    idle(32'h0);
    cycle(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1);
    idle(32'h0);
    idle(32'h0);
    // saturate bht[4] then step down once; still predicts taken
    repeat (4) cycle(1'b1, 32'h0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0);
    cycle(1'b1, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b1);
    idle(32'h0);
    idle(32'h300);
    idle(32'h0);
    // sequential wrap at the top of the address space
    cycle(1'b1, 32'h0, 1'b1, 32'h10, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);
    for (int n = 0; n < 400; n++) begin
      bt = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom() & 32'hFFFF_FFFC);
      cycle(1'($urandom_range(0, 3) != 0), bt, 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 5) == 0));
    end
    // async reset while in the redirect bubble
    cycle(1'b1, 32'h0, 1'b1, 32'h44, 1'b1, 32'h500, 1'b1);
    mon_en = 1'b0;
    chk("redir_valid_low", 32'(bus.fetch_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fetch_pc", bus.fetch_pc, 32'h100);
    chk("arst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("arst_cnt", bus.mispredict_cnt, 32'd0);
    chk("arst_pred_target", bus.pred_target, 32'h104);
    chk("arst_upd_addr", bus.btb_upd_addr, 32'd0);
    chk("arst_upd_entry", bus.btb_upd_entry, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
